fpdiv_rr_arbiter: RTL

//  Shares one iterative single-precision divider (start/done interface) among NREQ requesters.

---
 rtl/fpdiv_rr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fpdiv_rr_arbiter.sv
// Round-robin front end that shares one iterative fp divider (start/done) among NREQ requesters,
// with a watchdog that aborts a hung divide and returns a NaN result.
module fpdiv_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data,
  output logic [1:0]           resp_exc,
  output logic                 div_start,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic                 div_done,
  input  logic [31:0]          div_result,
  input  logic [1:0]           div_exc,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] NAN_RESULT = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, owner, grant_idx, scan_idx;
  logic [CW-1:0] wd_cnt;
  logic          found, wd_expire;
  logic [31:0]   sel_a, sel_b;

  // Grant search from ptr, next-state decode and combinational ready
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    wd_expire = (wd_cnt == CW'(TIMEOUT - 1));
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    case (state)
      S_IDLE: begin
        if (found) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = S_START;
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (div_done || wd_expire) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath; status outputs are registered from the next state
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ptr         <= '0;
      owner       <= '0;
      wd_cnt      <= '0;
      div_a       <= '0;
      div_b       <= '0;
      resp_data   <= '0;
      resp_exc    <= '0;
      resp_valid  <= '0;
      div_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      div_start  <= (state_nxt == S_START);
      busy       <= (state_nxt != S_IDLE);
      resp_valid <= (state_nxt == S_RESP) ? (NREQ'(1) << owner) : '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            div_a <= sel_a;
            div_b <= sel_b;
            owner <= grant_idx;
            ptr   <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
          end
        end
        S_START: wd_cnt <= '0;
        S_WAIT: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (div_done) begin
            resp_data <= div_result;
            resp_exc  <= div_exc;
          end else if (wd_expire) begin
            resp_data   <= NAN_RESULT;
            resp_exc    <= 2'b11;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
